// File: rtl/serial_tx_if.sv
// FIFO read-port bundle between the 16x9 TX FIFO (slave) and serial_tx (master).
// The FIFO is first-word-fall-through: rd_data is valid whenever empty is low.
interface serial_tx_if;
    logic       empty;
    logic [8:0] rd_data;
    logic       rd_request;

    modport master (input empty, input rd_data, output rd_request);
    modport slave  (output empty, output rd_data, input rd_request);
endinterface

// File: rtl/serial_tx.sv
// UART transmitter draining the TX FIFO; 24.8 fixed-point baud divisor, 5..9 data bits,
// optional parity and second stop bit. Define SERIAL_TX_BREAK_EN to add break generation.
module serial_tx #(
    parameter int unsigned BRD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          control,
    input  logic [BRD_WIDTH-1:0] brd,
    serial_tx_if.master          fifo,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned NW = BRD_WIDTH - 8;
    localparam int unsigned CW = NW + 1;

`ifdef SERIAL_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK, GUARD} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;
`endif

    state_e               state_q, state_d;
    logic [8:0]           word_q, word_d;
    logic [6:1]           cfg_q, cfg_d;
    logic [BRD_WIDTH-1:0] brd_q, brd_d;
    logic [7:0]           frac_q, frac_d;
    logic [3:0]           idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tx_q, tx_d;

    logic                 rd_req, pop_ok, bit_done, bit_start, frame_end, try_pop;
    logic [3:0]           d_bits;
    logic                 par_en, par_bit;
    logic [BRD_WIDTH-1:0] sel_brd;
    logic [8:0]           frac_sum;
    logic [NW-1:0]        n_sel;
    logic [CW-1:0]        bit_len;
    logic                 unused_ok;

`ifdef SERIAL_TX_BREAK_EN
    logic                 brk_q, brk_d;
    logic [NW-1:0]        n_live;
    assign n_live    = (brd[BRD_WIDTH-1:8] == '0) ? NW'(1) : brd[BRD_WIDTH-1:8];
    assign unused_ok = ^control[31:8];
`else
    assign unused_ok = ^control[31:7];
`endif

    assign pop_ok   = control[0] && !fifo.empty && !reset;
    assign bit_done = (cnt_q == '0);
    assign d_bits   = (cfg_q[3:1] > 3'd4) ? 4'd9 : {1'b0, cfg_q[3:1]} + 4'd5;
    assign par_en   = cfg_q[5] ^ cfg_q[4];

    // Odd parity seeds the XOR with 1; bits above the configured width never contribute.
    always_comb begin
        par_bit = cfg_q[5];
        for (int unsigned i = 0; i < 9; i++) begin
            if (i < 32'(d_bits)) par_bit = par_bit ^ word_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cfg_d     = cfg_q;
        brd_d     = brd_q;
        frac_d    = frac_q;
        idx_d     = idx_q;
        cnt_d     = bit_done ? cnt_q : cnt_q - CW'(1);
        rd_req    = 1'b0;
        bit_start = 1'b0;
        frame_end = 1'b0;
        try_pop   = 1'b0;
`ifdef SERIAL_TX_BREAK_EN
        brk_d     = brk_q;
`endif

        case (state_q)
            IDLE:   try_pop = 1'b1;
            START:  if (bit_done) begin
                        state_d   = DATA;
                        idx_d     = '0;
                        bit_start = 1'b1;
                    end
            DATA:   if (bit_done) begin
                        bit_start = 1'b1;
                        if (idx_q == d_bits - 4'd1) state_d = par_en ? PARITY : STOP1;
                        else                        idx_d   = idx_q + 4'd1;
                    end
            PARITY: if (bit_done) begin
                        state_d   = STOP1;
                        bit_start = 1'b1;
                    end
            STOP1:  if (bit_done) begin
                        if (cfg_q[6]) begin
                            state_d   = STOP2;
                            bit_start = 1'b1;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
            STOP2:  if (bit_done) frame_end = 1'b1;
`ifdef SERIAL_TX_BREAK_EN
            BRK:    if (!control[7]) begin
                        state_d = GUARD;
                        cnt_d   = {1'b0, n_live} - CW'(1);
                    end
            GUARD:  if (bit_done) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            state_d = IDLE;
            try_pop = 1'b1;
        end

`ifdef SERIAL_TX_BREAK_EN
        if ((state_q == IDLE && control[7]) || (frame_end && brk_q)) begin
            state_d = BRK;
            try_pop = 1'b0;
        end
`endif

        if (try_pop && pop_ok) begin
            rd_req    = 1'b1;
            word_d    = fifo.rd_data;
            cfg_d     = control[6:1];
            brd_d     = brd;
            state_d   = START;
            bit_start = 1'b1;
`ifdef SERIAL_TX_BREAK_EN
            brk_d     = control[7];
`endif
        end

        // A pop restarts the fraction accumulator and times START from the freshly latched divisor.
        sel_brd  = rd_req ? brd : brd_q;
        frac_sum = {1'b0, rd_req ? 8'h00 : frac_q} + {1'b0, sel_brd[7:0]};
        n_sel    = (sel_brd[BRD_WIDTH-1:8] == '0) ? NW'(1) : sel_brd[BRD_WIDTH-1:8];
        bit_len  = {1'b0, n_sel} + CW'(frac_sum[8]);
        if (bit_start) begin
            cnt_d  = bit_len - CW'(1);
            frac_d = frac_sum[7:0];
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = word_q[idx_d];
            PARITY:  tx_d = par_bit;
`ifdef SERIAL_TX_BREAK_EN
            BRK:     tx_d = 1'b0;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            cfg_q   <= '0;
            brd_q   <= '0;
            frac_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
`ifdef SERIAL_TX_BREAK_EN
            brk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cfg_q   <= cfg_d;
            brd_q   <= brd_d;
            frac_q  <= frac_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
`ifdef SERIAL_TX_BREAK_EN
            brk_q   <= brk_d;
`endif
        end
    end

    assign fifo.rd_request = rd_req;
    assign tx              = tx_q;
    assign busy            = rd_req || (state_q inside {START, DATA, PARITY, STOP1, STOP2});

endmodule
